bin2bcd_seq: RTL

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 132 +++++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: shift-add-3 (double dabble), one input bit per clock, MSB first.
// Optional `BIN2BCD_OVERFLOW_EN enables a registered overflow flag; otherwise overflow is tied low.
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      binary,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state, state_nx;
    logic              accept;
    logic              last;
    logic [WIDTH-1:0]  bin_sr;
    logic [WIDTH-1:0]  bin_nx;
    logic [SW-1:0]     scratch;
    logic [SW-1:0]     scratch_nx;
    logic [CW-1:0]     cnt;

    // Correct every BCD digit that would exceed 9 after the next doubling.
    function automatic logic [SW-1:0] dabble_adjust(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign bin_nx = {bin_sr[WIDTH-2:0], 1'b0};

`ifdef BIN2BCD_OVERFLOW_EN
    logic [SW:0] grown;
    logic        carry_out;
    logic        ovf_flag;

    assign grown      = {dabble_adjust(scratch), bin_sr[WIDTH-1]};
    assign scratch_nx = grown[SW-1:0];
    assign carry_out  = grown[SW];
`else
    // Bit leaving the top digit is dropped, giving value mod 10^DIGITS.
    assign scratch_nx = SW'({dabble_adjust(scratch), bin_sr[WIDTH-1]});
`endif

    assign busy = (state == SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                last = (cnt == CW'(WIDTH - 1));
                if (last)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_sr  <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                bin_sr  <= binary;
                scratch <= '0;
                cnt     <= '0;
            end else if (state == SHIFT) begin
                bin_sr  <= bin_nx;
                scratch <= scratch_nx;
                cnt     <= cnt + CW'(1);
                // bcd only ever sees the finished result.
                if (last) begin
                    bcd  <= scratch_nx;
                    done <= 1'b1;
                end
            end
        end
    end

`ifdef BIN2BCD_OVERFLOW_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_flag <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            ovf_flag <= 1'b0;
        end else if (state == SHIFT) begin
            ovf_flag <= ovf_flag | carry_out;
            if (last)
                overflow <= ovf_flag | carry_out;
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule
